// File: rtl/mist32_membus_responder.sv
// Target end of the mist32 memory bus: 64-bit line RAM with in-order read
// responses through a fixed-latency pipeline and a small response FIFO.
module mist32_membus_responder #(
  parameter int P_DEPTH_LOG2   = 10,
  parameter int P_READ_LATENCY = 2,
  parameter int P_RESP_DEPTH   = 4
) (
  input  logic        iCLOCK,
  input  logic        iRESET,
  input  logic        iMEMORY_REQ,
  output logic        oMEMORY_LOCK,
  input  logic [1:0]  iMEMORY_ORDER,
  input  logic [3:0]  iMEMORY_MASK,
  input  logic        iMEMORY_RW,
  input  logic [31:0] iMEMORY_ADDR,
  input  logic [31:0] iMEMORY_DATA,
  output logic        oMEMORY_VALID,
  input  logic        iMEMORY_BUSY,
  output logic [63:0] oMEMORY_DATA
);

  localparam int LINES = 1 << P_DEPTH_LOG2;
  localparam int CNT_W = $clog2(P_RESP_DEPTH + 1);
  localparam int PTR_W = $clog2(P_RESP_DEPTH);

  logic [63:0] mem [LINES];
  logic [63:0] pipeData_q [P_READ_LATENCY];
  logic [63:0] fifo_q [P_RESP_DEPTH];

  logic [P_READ_LATENCY-1:0] pipeVld_q;
  logic [PTR_W-1:0]          wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]          fifoCnt_q, fifoCnt_d, outCnt_q, outCnt_d;

  logic [P_DEPTH_LOG2-1:0] lineIdx;
  logic accept, readAccept, writeAccept, push, pop;
  logic unusedAddr;

  assign lineIdx    = iMEMORY_ADDR[P_DEPTH_LOG2+2:3];
  assign unusedAddr = ^{iMEMORY_ADDR[31:P_DEPTH_LOG2+3], iMEMORY_ADDR[1:0]};

  // LOCK counts reads still in the pipeline as well as queued ones, so the FIFO cannot overflow.
  assign oMEMORY_LOCK  = (outCnt_q == CNT_W'(P_RESP_DEPTH));
  assign accept        = iMEMORY_REQ && !oMEMORY_LOCK;
  assign readAccept    = accept && !iMEMORY_RW;
  assign writeAccept   = accept && iMEMORY_RW && (iMEMORY_ORDER != 2'b11);
  assign push          = pipeVld_q[P_READ_LATENCY-1];
  assign pop           = (fifoCnt_q != '0) && !iMEMORY_BUSY;
  assign oMEMORY_VALID = pop;
  assign oMEMORY_DATA  = pop ? fifo_q[rdPtr_q] : 64'h0;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (push) wrPtr_d = (wrPtr_q == PTR_W'(P_RESP_DEPTH - 1)) ? '0 : wrPtr_q + 1'b1;
    if (pop)  rdPtr_d = (rdPtr_q == PTR_W'(P_RESP_DEPTH - 1)) ? '0 : rdPtr_q + 1'b1;
    fifoCnt_d = fifoCnt_q + CNT_W'(push) - CNT_W'(pop);
    outCnt_d  = outCnt_q + CNT_W'(readAccept) - CNT_W'(pop);
  end

  // Storage only; validity is carried by the reset flops below.
  always_ff @(posedge iCLOCK) begin
    if (writeAccept) begin
      for (int b = 0; b < 4; b++) begin
        if (iMEMORY_MASK[b]) mem[lineIdx][{~iMEMORY_ADDR[2], b[1:0], 3'b000} +: 8] <= iMEMORY_DATA[8*b +: 8];
      end
    end
    if (readAccept) pipeData_q[0] <= mem[lineIdx];
    for (int i = 1; i < P_READ_LATENCY; i++) pipeData_q[i] <= pipeData_q[i-1];
    if (push) fifo_q[wrPtr_q] <= pipeData_q[P_READ_LATENCY-1];
  end

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      pipeVld_q <= '0;
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      fifoCnt_q <= '0;
      outCnt_q  <= '0;
    end else begin
      pipeVld_q[0] <= readAccept;
      for (int i = 1; i < P_READ_LATENCY; i++) pipeVld_q[i] <= pipeVld_q[i-1];
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      fifoCnt_q <= fifoCnt_d;
      outCnt_q  <= outCnt_d;
    end
  end

endmodule

// File: tb/tb_mist32_membus_responder.sv
// Bench for mist32_membus_responder: directed scenarios then random traffic,
// all checked against a line-array and response-queue model of the bus.
module tb_mist32_membus_responder;

  localparam int DLOG  = 10;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic        iCLOCK = 1'b0;
  logic        iRESET = 1'b1;
  logic        iMEMORY_REQ = 1'b0;
  logic        oMEMORY_LOCK;
  logic [1:0]  iMEMORY_ORDER = 2'b10;
  logic [3:0]  iMEMORY_MASK = 4'h0;
  logic        iMEMORY_RW = 1'b0;
  logic [31:0] iMEMORY_ADDR = 32'h0;
  logic [31:0] iMEMORY_DATA = 32'h0;
  logic        oMEMORY_VALID;
  logic        iMEMORY_BUSY = 1'b0;
  logic [63:0] oMEMORY_DATA;

  mist32_membus_responder #(
    .P_DEPTH_LOG2(DLOG), .P_READ_LATENCY(LAT), .P_RESP_DEPTH(DEPTH)
  ) dut (
    .iCLOCK(iCLOCK), .iRESET(iRESET),
    .iMEMORY_REQ(iMEMORY_REQ), .oMEMORY_LOCK(oMEMORY_LOCK),
    .iMEMORY_ORDER(iMEMORY_ORDER), .iMEMORY_MASK(iMEMORY_MASK),
    .iMEMORY_RW(iMEMORY_RW), .iMEMORY_ADDR(iMEMORY_ADDR),
    .iMEMORY_DATA(iMEMORY_DATA), .oMEMORY_VALID(oMEMORY_VALID),
    .iMEMORY_BUSY(iMEMORY_BUSY), .oMEMORY_DATA(oMEMORY_DATA)
  );

  always #5 iCLOCK = ~iCLOCK;

  typedef struct {
    logic [63:0] data;
    int          ready;
  } resp_t;

  resp_t       respQ[$];
  logic [63:0] refMem [1 << DLOG];
  logic [31:0] preHi [16];
  int          total = 0;
  int          bad = 0;
  int          cycleNo = 0;
  logic        obsValid, obsLock;
  logic [63:0] obsData;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One bus cycle: drive inputs, check outputs mid-cycle, then advance the model past the edge.
  task automatic applyStimulus(input logic req, input logic rw, input logic [1:0] order,
                               input logic [3:0] mask, input logic [31:0] addr,
                               input logic [31:0] data, input logic busy);
    logic        expLock, expValid;
    logic [63:0] expData, line;
    int          idx, j;
    iMEMORY_REQ = req; iMEMORY_RW = rw; iMEMORY_ORDER = order; iMEMORY_MASK = mask;
    iMEMORY_ADDR = addr; iMEMORY_DATA = data; iMEMORY_BUSY = busy;
    @(negedge iCLOCK);
    expLock  = (respQ.size() == DEPTH);
    expValid = (respQ.size() > 0) && (respQ[0].ready <= cycleNo) && !busy;
    expData  = expValid ? respQ[0].data : 64'h0;
    obsValid = oMEMORY_VALID; obsLock = oMEMORY_LOCK; obsData = oMEMORY_DATA;
    checkOutput("lock", {63'h0, obsLock}, {63'h0, expLock});
    checkOutput("valid", {63'h0, obsValid}, {63'h0, expValid});
    checkOutput("data", obsData, expData);
    if (expValid) respQ.delete(0);
    if (req && !expLock) begin
      idx = int'(addr[DLOG+2:3]);
      if (rw) begin
        if (order != 2'b11) begin
          line = refMem[idx];
          for (int k = 0; k < 4; k++) begin
            if (mask[3-k]) begin
              j = (addr[2] ? 4 : 0) + k;
              line[63-8*j -: 8] = data[31-8*k -: 8];
            end
          end
          refMem[idx] = line;
        end
      end else begin
        respQ.push_back('{refMem[idx], cycleNo + LAT + 1});
      end
    end
    @(posedge iCLOCK); #1;
    cycleNo++;
  endtask

  task automatic idleCycles(input int n, input logic busy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 2'b10, 4'h0, 32'h0, 32'h0, busy);
  endtask

  task automatic applyReset(input int cycles);
    iRESET = 1'b1; iMEMORY_REQ = 1'b0; iMEMORY_BUSY = 1'b0;
    #1;
    checkOutput("rstValid", {63'h0, oMEMORY_VALID}, 64'h0);
    checkOutput("rstLock", {63'h0, oMEMORY_LOCK}, 64'h0);
    checkOutput("rstData", oMEMORY_DATA, 64'h0);
    respQ.delete();
    for (int i = 0; i < cycles; i++) begin
      @(posedge iCLOCK); #1;
      cycleNo++;
    end
    iRESET = 1'b0;
  endtask

  initial begin
    int          acc;
    logic [31:0] w, a;
    @(posedge iCLOCK); #1;
    applyReset(2);

    // Preload lines 0..15 with known random words.
    for (int l = 0; l < 16; l++) begin
      preHi[l] = $urandom;
      w = $urandom;
      applyStimulus(1'b1, 1'b1, 2'b10, 4'hF, 32'(l) << 3, preHi[l], 1'b0);
      applyStimulus(1'b1, 1'b1, 2'b10, 4'hF, (32'(l) << 3) | 32'h4, w, 1'b0);
    end

    $display("[TB] write then read, latency and data");
    applyStimulus(1'b1, 1'b1, 2'b10, 4'hF, 32'h0002_0004, 32'h1122_3344, 1'b0);
    applyStimulus(1'b1, 1'b0, 2'b10, 4'hF, 32'h0002_0000, 32'h0, 1'b0);
    idleCycles(2, 1'b0);
    checkOutput("t1NotYet", {63'h0, obsValid}, 64'h0);
    idleCycles(1, 1'b0);
    checkOutput("t1Valid", {63'h0, obsValid}, 64'h1);
    checkOutput("t1Lo", {32'h0, obsData[31:0]}, 64'h1122_3344);
    checkOutput("t1Hi", {32'h0, obsData[63:32]}, {32'h0, preHi[0]});

    $display("[TB] partial byte-lane write");
    applyStimulus(1'b1, 1'b1, 2'b10, 4'hF, 32'h10, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'b10, 4'hF, 32'h14, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'b10, 4'b0100, 32'h10, 32'hAABB_CCDD, 1'b0);
    applyStimulus(1'b1, 1'b0, 2'b10, 4'hF, 32'h10, 32'h0, 1'b0);
    idleCycles(3, 1'b0);
    checkOutput("t2Data", obsData, 64'h00BB_0000_0000_0000);

    $display("[TB] backpressure fills the response path");
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b0, 2'b10, 4'hF, 32'(4 + i) << 3, 32'h0, 1'b1);
      if (!obsLock) acc++;
    end
    checkOutput("t3Accepts", 64'(acc), 64'd4);
    idleCycles(1, 1'b0);
    checkOutput("t3LockOnPop", {63'h0, obsLock}, 64'h1);
    idleCycles(1, 1'b0);
    checkOutput("t3LockDrop", {63'h0, obsLock}, 64'h0);
    idleCycles(4, 1'b0);

    $display("[TB] address aliasing");
    applyStimulus(1'b1, 1'b0, 2'b10, 4'hF, 32'h0000_2000, 32'h0, 1'b0);
    idleCycles(3, 1'b0);
    checkOutput("t4Alias", obsData, refMem[0]);

    $display("[TB] reset with reads outstanding");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 2'b10, 4'hF, 32'(i) << 3, 32'h0, 1'b0);
    applyReset(2);
    idleCycles(6, 1'b0);
    applyStimulus(1'b1, 1'b0, 2'b10, 4'hF, 32'h0002_0000, 32'h0, 1'b0);
    idleCycles(3, 1'b0);
    checkOutput("t5Kept", {32'h0, obsData[31:0]}, 64'h1122_3344);

    $display("[TB] random traffic");
    for (int n = 0; n < 3000; n++) begin
      a = ($urandom & 32'hFFFF_E007) | (32'($urandom_range(0, 15)) << 3);
      applyStimulus($urandom_range(0, 9) < 7, 1'($urandom), 2'($urandom), 4'($urandom),
                    a, $urandom, $urandom_range(0, 9) < 3);
    end
    idleCycles(DEPTH + LAT + 2, 1'b0);
    checkOutput("drained", 64'(respQ.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
